// File: rtl/lsu_pkg.sv
// lsu_pkg: shared memOp encodings, FSM states and access-size helpers for the LSU
package lsu_pkg;
  localparam logic [2:0] MOP_B  = 3'd0;
  localparam logic [2:0] MOP_H  = 3'd1;
  localparam logic [2:0] MOP_W  = 3'd2;
  localparam logic [2:0] MOP_BU = 3'd4;
  localparam logic [2:0] MOP_HU = 3'd5;
  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_WAIT, S_RESP} state_t;
  function automatic logic [2:0] op_size(input logic [2:0] op);
    return op[1:0] == 2'd0 ? 3'd1 : op[1:0] == 2'd1 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic op_legal(input logic [2:0] op, input logic we);
    return we ? (op <= MOP_W) : (op <= MOP_W || op == MOP_BU || op == MOP_HU);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane shifting/masking and load half merging with extension
module lsu_lane_align (
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [3:0]  mask0,
  output logic [3:0]  mask1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);
  logic [3:0]  sm;
  logic [5:0]  sh_lo, sh_hi;
  logic [31:0] merged;
  // Beat 0 carries the low lanes shifted up; beat 1 carries the overflow shifted down.
  always_comb begin
    sm = size == 3'd4 ? 4'hf : size == 3'd2 ? 4'h3 : 4'h1;
    sh_lo = {1'b0, off, 3'b000};
    sh_hi = 6'd32 - sh_lo;
    mask0 = sm << off;
    mask1 = sm >> (3'd4 - {1'b0, off});
    wdata0 = wdata << sh_lo;
    wdata1 = wdata >> sh_hi;
    merged = (hi << sh_hi) | (lo >> sh_lo);
    rdata = size == 3'd4 ? merged :
            size == 3'd2 ? {{16{sext & merged[15]}}, merged[15:0]} :
                           {{24{sext & merged[7]}}, merged[7:0]};
  end
endmodule

// File: rtl/lsu_access_splitter.sv
// lsu_access_splitter: splits execute-stage accesses into word-aligned memory beats
module lsu_access_splitter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_memOp,
  input  logic              req_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  import lsu_pkg::*;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, word_addr;
  logic [DATA_W-1:0] wdata_q, lo_q, hi_q;
  logic [2:0] op_q, size_in, size;
  logic we_q, err_q, accept, bad_in, split, beat0, beat1;
  logic [1:0] off_in, off;
  logic [3:0] mask0, mask1;
  logic [31:0] wdata0, wdata1, ld_data;
  // Classify the incoming request and the latched access.
  always_comb begin
    accept = req_valid && state_q == S_IDLE;
    off_in = req_addr[1:0];
    size_in = op_size(req_memOp);
    bad_in = !op_legal(req_memOp, req_we) || (ALLOW_MISALIGNED == 0 &&
             ((size_in == 3'd2 && off_in[0]) || (size_in == 3'd4 && off_in != 2'd0)));
    off = addr_q[1:0];
    size = op_size(op_q);
    split = ({2'b00, off} + {1'b0, size}) > 4'd4;
    word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  end
  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  // Next state: errors skip the memory beats, loads wait one cycle for the last word.
  always_comb begin
    state_d = state_q == S_IDLE  ? (accept ? (bad_in ? S_RESP : S_BEAT0) : S_IDLE) :
              state_q == S_BEAT0 ? (split ? S_BEAT1 : we_q ? S_RESP : S_WAIT) :
              state_q == S_BEAT1 ? (we_q ? S_RESP : S_WAIT) :
              state_q == S_WAIT  ? S_RESP : S_IDLE;
  end
  // Request latch and load-word capture, one cycle after each read strobe.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      op_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        op_q <= req_memOp;
        we_q <= req_we;
        err_q <= bad_in;
        hi_q <= '0;
      end
      if (state_q == S_BEAT1 && !we_q) lo_q <= mem_rdata;
      if (state_q == S_WAIT) begin
        if (split) hi_q <= mem_rdata;
        else lo_q <= mem_rdata;
      end
    end
  lsu_lane_align u_align (
    .off(off), .size(size), .sext(!op_q[2]), .wdata(wdata_q), .lo(lo_q), .hi(hi_q),
    .mask0(mask0), .mask1(mask1), .wdata0(wdata0), .wdata1(wdata1), .rdata(ld_data)
  );
  // Outputs decode purely from registered state, so they are quiet in IDLE.
  always_comb begin
    beat0 = state_q == S_BEAT0;
    beat1 = state_q == S_BEAT1;
    req_ready = state_q == S_IDLE;
    mem_addr = beat0 ? word_addr : beat1 ? word_addr + ADDR_W'(4) : '0;
    mem_we = (beat0 || beat1) && we_q;
    mem_re = (beat0 || beat1) && !we_q;
    mem_wmask = mem_we ? (beat0 ? mask0 : mask1) : 4'h0;
    mem_wdata = mem_we ? (beat0 ? wdata0 : wdata1) : '0;
    rsp_valid = state_q == S_RESP;
    rsp_err = rsp_valid && err_q;
    rsp_rdata = rsp_valid && !we_q && !err_q ? ld_data : '0;
  end
endmodule

// File: tb/tb_lsu_access_splitter.sv
// tb_lsu_access_splitter: scoreboard bench for the LSU access splitter
module tb_lsu_access_splitter;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic [2:0] req_memOp = 0;
  logic req_ready, mem_we, mem_re, rsp_valid, rsp_err;
  logic [31:0] mem_addr, mem_wdata, rsp_rdata;
  logic [3:0] mem_wmask;
  logic n_req_ready, n_mem_we, n_mem_re, n_rsp_valid, n_rsp_err;
  logic [31:0] n_mem_addr, n_mem_wdata, n_rsp_rdata;
  logic [3:0] n_mem_wmask;
  int cyc = 0, passed = 0, total = 0, both_high = 0, n_beats = 0;
  typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; logic we; int c;} beat_t;
  exp_t sb[$];
  beat_t beats[$];
  logic [31:0] mem [logic [29:0]];
  logic [31:0] wtmp;

  lsu_access_splitter #(.ADDR_W(32), .DATA_W(32), .ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_memOp(req_memOp), .req_we(req_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));
  lsu_access_splitter #(.ADDR_W(32), .DATA_W(32), .ALLOW_MISALIGNED(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(n_req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_memOp(req_memOp), .req_we(req_we), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .mem_wmask(n_mem_wmask), .mem_we(n_mem_we), .mem_re(n_mem_re),
    .mem_rdata(mem_rdata), .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata), .rsp_err(n_rsp_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rdw(input logic [29:0] k);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  // Byte-wise little-endian reference for a load.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v, ba, w;
    int n;
    v = 0;
    n = op[1:0] == 2'd0 ? 1 : op[1:0] == 2'd1 ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      ba = a + i;
      w = rdw(ba[31:2]);
      v[8*i +: 8] = w[8*ba[1:0] +: 8];
    end
    if (!op[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!op[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= mem_re ? rdw(mem_addr[31:2]) : 32'h0;
    if (mem_we) begin
      wtmp = rdw(mem_addr[31:2]);
      for (int i = 0; i < 4; i++) if (mem_wmask[i]) wtmp[8*i +: 8] = mem_wdata[8*i +: 8];
      mem[mem_addr[31:2]] = wtmp;
    end
  end

  always @(negedge clk) begin
    if (mem_we || mem_re) beats.push_back('{mem_addr, mem_wdata, mem_wmask, mem_we, cyc});
    if (mem_we && mem_re) both_high++;
    if (n_mem_we || n_mem_re) n_beats++;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                      input logic we, output int acc, output logic rdy);
    @(negedge clk);
    req_addr = a; req_wdata = d; req_memOp = op; req_we = we; req_valid = 1; rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 0;
    acc = cyc;
  endtask

  task automatic wait_rsp(output logic got, output logic [31:0] rd, output logic er, output int c);
    got = 0; rd = 0; er = 0; c = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; rd = rsp_rdata; er = rsp_err; c = cyc; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (req_ready === 1'b1) passed++; else $display("FAIL reset_ready: got %b want 1", req_ready);
    total++;
    if ({mem_we, mem_re, rsp_valid, rsp_err} === 4'b0) passed++;
    else $display("FAIL reset_strobes: got %b want 0000", {mem_we, mem_re, rsp_valid, rsp_err});
    total++;
    if (mem_addr === 0 && mem_wdata === 0 && mem_wmask === 0 && rsp_rdata === 0) passed++;
    else $display("FAIL reset_data: got addr %h wdata %h mask %b rdata %h want 0", mem_addr, mem_wdata, mem_wmask, rsp_rdata);
    rst = 0;
    @(negedge clk);
    total++; if (req_ready === 1'b1) passed++; else $display("FAIL post_reset_ready: got %b want 1", req_ready);
  endtask

  task automatic test_load_word;
    int a, c, b0; logic got, er, rdy; logic [31:0] rd; exp_t e;
    mem[30'h40] = 32'hDEADBEEF;
    b0 = beats.size();
    sb.push_back('{rdata: 32'hDEADBEEF, err: 0, lat: 3});
    send(32'h100, 0, lsu_pkg::MOP_W, 0, a, rdy);
    @(negedge clk);
    total++; if (req_ready === 1'b0) passed++; else $display("FAIL busy_ready: got %b want 0", req_ready);
    wait_rsp(got, rd, er, c);
    e = sb.pop_front();
    total++; if (got && rd === e.rdata && er === e.err) passed++;
    else $display("FAIL lw_data: got %h err %b valid %b want %h err %b", rd, er, got, e.rdata, e.err);
    total++; if (c - a + 1 == e.lat) passed++; else $display("FAIL lw_lat: got %0d want %0d", c - a + 1, e.lat);
    total++; if (beats.size() - b0 == 1 && beats[b0].addr === 32'h100 && beats[b0].we === 1'b0) passed++;
    else $display("FAIL lw_beat: got %0d beats want 1 read at 00000100", beats.size() - b0);
  endtask

  task automatic test_load_byte;
    int a, c; logic got, er, rdy; logic [31:0] rd; exp_t e;
    logic [2:0] ops [2] = '{lsu_pkg::MOP_B, lsu_pkg::MOP_BU};
    logic [31:0] want [2] = '{32'hFFFFFF80, 32'h00000080};
    mem[30'h40] = 32'h80FFFFFF;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{rdata: want[i], err: 0, lat: 3});
      send(32'h103, 0, ops[i], 0, a, rdy);
      wait_rsp(got, rd, er, c);
      e = sb.pop_front();
      total++; if (got && rd === e.rdata && er === e.err) passed++;
      else $display("FAIL lb_data op%0d: got %h err %b want %h", ops[i], rd, er, e.rdata);
      total++; if (c - a + 1 == e.lat) passed++; else $display("FAIL lb_lat op%0d: got %0d want %0d", ops[i], c - a + 1, e.lat);
    end
  endtask

  task automatic test_split_store;
    int a, c, b0; logic got, er, rdy; logic [31:0] rd; exp_t e;
    logic [31:0] ra [2] = '{32'h100, 32'h104};
    b0 = beats.size();
    sb.push_back('{rdata: 0, err: 0, lat: 3});
    send(32'h102, 32'h11223344, lsu_pkg::MOP_W, 1, a, rdy);
    wait_rsp(got, rd, er, c);
    e = sb.pop_front();
    total++; if (got && rd === e.rdata && er === e.err) passed++;
    else $display("FAIL sw_rsp: got %h err %b valid %b want 0", rd, er, got);
    total++; if (c - a + 1 == e.lat) passed++; else $display("FAIL sw_lat: got %0d want %0d", c - a + 1, e.lat);
    total++;
    if (beats.size() - b0 == 2 && beats[b0].addr === 32'h100 && beats[b0].mask === 4'b1100 &&
        beats[b0].wdata === 32'h33440000 && beats[b0].we === 1'b1) passed++;
    else $display("FAIL sw_beat0: got %0d beats, first addr %h", beats.size() - b0, beats[b0].addr);
    total++;
    if (beats.size() - b0 == 2 && beats[b0+1].addr === 32'h104 && beats[b0+1].mask === 4'b0011 &&
        beats[b0+1].wdata === 32'h00001122 && beats[b0+1].c == beats[b0].c + 1) passed++;
    else $display("FAIL sw_beat1: got addr %h mask %b wdata %h want 00000104 0011 00001122",
                  beats[b0+1].addr, beats[b0+1].mask, beats[b0+1].wdata);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{rdata: ref_load(ra[i], lsu_pkg::MOP_W), err: 0, lat: 3});
      send(ra[i], 0, lsu_pkg::MOP_W, 0, a, rdy);
      total++; if (rdy === 1'b1) passed++; else $display("FAIL b2b_ready: got %b want 1", rdy);
      wait_rsp(got, rd, er, c);
      e = sb.pop_front();
      total++; if (got && rd === e.rdata && c - a + 1 == e.lat) passed++;
      else $display("FAIL sw_readback%0d: got %h lat %0d want %h lat %0d", i, rd, c - a + 1, e.rdata, e.lat);
    end
  endtask

  task automatic test_wrap;
    int a, c, b0; logic got, er, rdy; logic [31:0] rd; exp_t e;
    mem[30'h3FFFFFFF] = 32'hAB000000;
    mem[30'h0] = 32'h000000CD;
    b0 = beats.size();
    sb.push_back('{rdata: 32'hFFFFCDAB, err: 0, lat: 4});
    send(32'hFFFFFFFF, 0, lsu_pkg::MOP_H, 0, a, rdy);
    wait_rsp(got, rd, er, c);
    e = sb.pop_front();
    total++; if (got && rd === e.rdata && er === e.err) passed++;
    else $display("FAIL wrap_data: got %h err %b want %h", rd, er, e.rdata);
    total++; if (c - a + 1 == e.lat) passed++; else $display("FAIL wrap_lat: got %0d want %0d", c - a + 1, e.lat);
    total++; if (beats.size() - b0 == 2 && beats[b0].addr === 32'hFFFFFFFC && beats[b0+1].addr === 32'h0) passed++;
    else $display("FAIL wrap_addr: got %0d beats second addr %h want 2 beats at FFFFFFFC/00000000",
                  beats.size() - b0, beats[b0+1].addr);
  endtask

  task automatic test_errors;
    int a, c, b0, nb0; logic got, er, rdy; logic [31:0] rd; exp_t e;
    logic [2:0] eop [2] = '{3'd3, lsu_pkg::MOP_BU};
    logic ewe [2] = '{1'b0, 1'b1};
    nb0 = n_beats;
    sb.push_back('{rdata: ref_load(32'h101, lsu_pkg::MOP_W), err: 0, lat: 4});
    send(32'h101, 0, lsu_pkg::MOP_W, 0, a, rdy);
    @(negedge clk);
    total++; if (n_rsp_valid === 1'b1 && n_rsp_err === 1'b1 && n_rsp_rdata === 0) passed++;
    else $display("FAIL strict_err: got valid %b err %b rdata %h want 1 1 0", n_rsp_valid, n_rsp_err, n_rsp_rdata);
    wait_rsp(got, rd, er, c);
    e = sb.pop_front();
    total++; if (got && rd === e.rdata && er === e.err && c - a + 1 == e.lat) passed++;
    else $display("FAIL split_lw: got %h err %b lat %0d want %h 0 %0d", rd, er, c - a + 1, e.rdata, e.lat);
    total++; if (n_beats - nb0 == 0) passed++; else $display("FAIL strict_beats: got %0d want 0", n_beats - nb0);
    for (int i = 0; i < 2; i++) begin
      b0 = beats.size();
      sb.push_back('{rdata: 0, err: 1, lat: 1});
      send(32'h100, 32'h55, eop[i], ewe[i], a, rdy);
      wait_rsp(got, rd, er, c);
      e = sb.pop_front();
      total++; if (got && rd === e.rdata && er === e.err) passed++;
      else $display("FAIL illegal_op%0d: got %h err %b want %h err 1", eop[i], rd, er, e.rdata);
      total++; if (c - a + 1 == e.lat && beats.size() == b0) passed++;
      else $display("FAIL illegal_lat%0d: got lat %0d beats %0d want 1 0", eop[i], c - a + 1, beats.size() - b0);
    end
  endtask

  task automatic test_reset_mid;
    int a, c; logic got, er, rdy; logic [31:0] rd; exp_t e;
    mem[30'h80] = 0;
    mem[30'h81] = 0;
    send(32'h202, 32'hAABBCCDD, lsu_pkg::MOP_W, 1, a, rdy);
    @(posedge clk);
    #1;
    total++; if (mem_we === 1'b1 && mem_addr === 32'h204) passed++;
    else $display("FAIL mid_beat1: got we %b addr %h want 1 00000204", mem_we, mem_addr);
    #1 rst = 1;
    #1;
    total++; if (mem_we === 1'b0 && mem_re === 1'b0) passed++; else $display("FAIL mid_rst_we: got %b want 0", mem_we);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++; if (req_ready === 1'b1) passed++; else $display("FAIL mid_ready: got %b want 1", req_ready);
    total++; if (rdw(30'h80) === 32'hCCDD0000 && rdw(30'h81) === 32'h0) passed++;
    else $display("FAIL mid_mem: got %h %h want CCDD0000 00000000", rdw(30'h80), rdw(30'h81));
    sb.push_back('{rdata: 32'hCCDD0000, err: 0, lat: 3});
    send(32'h200, 0, lsu_pkg::MOP_W, 0, a, rdy);
    wait_rsp(got, rd, er, c);
    e = sb.pop_front();
    total++; if (got && rd === e.rdata && er === e.err && c - a + 1 == e.lat) passed++;
    else $display("FAIL mid_next: got %h err %b lat %0d want %h lat %0d", rd, er, c - a + 1, e.rdata, e.lat);
  endtask

  task automatic test_random_loads;
    int a, c; logic got, er, rdy; logic [31:0] rd, ad; exp_t e; logic [2:0] op; int sz;
    logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int k = 0; k < 4; k++) mem[30'hC0 + k] = $urandom;
    for (int i = 0; i < 10; i++) begin
      op = ops[$urandom_range(0, 4)];
      ad = 32'h300 + $urandom_range(0, 7);
      sz = op[1:0] == 2'd0 ? 1 : op[1:0] == 2'd1 ? 2 : 4;
      sb.push_back('{rdata: ref_load(ad, op), err: 0, lat: (int'(ad[1:0]) + sz > 4) ? 4 : 3});
      send(ad, 0, op, 0, a, rdy);
      wait_rsp(got, rd, er, c);
      e = sb.pop_front();
      total++; if (got && rd === e.rdata && er === e.err && c - a + 1 == e.lat) passed++;
      else $display("FAIL rand_ld op%0d addr %h: got %h lat %0d want %h lat %0d", op, ad, rd, c - a + 1, e.rdata, e.lat);
    end
    total++; if (both_high == 0) passed++; else $display("FAIL we_re_overlap: got %0d want 0", both_high);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    test_load_word;
    test_load_byte;
    test_split_store;
    test_wrap;
    test_errors;
    test_reset_mid;
    test_random_loads;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
